// File: rtl/pagerank_pkg.sv
// Shared types for the pagerank scatter arbiter: controller states and the per-engine update word.
// Widths here fix the update format for every engine FIFO and the gather port.
package pagerank_pkg;

    localparam int ID_W    = 32;
    localparam int VALUE_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } ctrl_state_t;

    typedef struct packed {
        logic [ID_W-1:0]    node_id;
        logic [VALUE_W-1:0] value;
    } scatter_update_t;

endpackage

// File: rtl/pagerank_scatter_arbiter_if.sv
// Scatter-engine update streams in, merged gather-stage update port out.
// The arbiter takes the slave side; the engine bank / gather stage drive the master side.
interface pagerank_scatter_arbiter_if
    import pagerank_pkg::*;
#(
    parameter int NUM_SCATTER = 4
);
    localparam int SRC_W = (NUM_SCATTER > 1) ? $clog2(NUM_SCATTER) : 1;

    logic [NUM_SCATTER-1:0]               sc_valid;
    logic [NUM_SCATTER-1:0][ID_W-1:0]     sc_node_id;
    logic [NUM_SCATTER-1:0][VALUE_W-1:0]  sc_value;
    logic [NUM_SCATTER-1:0]               sc_done;
    logic [NUM_SCATTER-1:0]               sc_ready;

    logic                                 gather_valid;
    logic                                 gather_ready;
    logic [ID_W-1:0]                      gather_node_id;
    logic [VALUE_W-1:0]                   gather_value;
    logic [SRC_W-1:0]                     gather_src;

    modport master (
        output sc_valid, sc_node_id, sc_value, sc_done, gather_ready,
        input  sc_ready, gather_valid, gather_node_id, gather_value, gather_src
    );

    modport slave (
        input  sc_valid, sc_node_id, sc_value, sc_done, gather_ready,
        output sc_ready, gather_valid, gather_node_id, gather_value, gather_src
    );

endinterface

// File: rtl/pagerank_update_fifo.sv
// Per-engine update FIFO; data visible on o_dat the cycle after the push edge, no bypass.
// Push ignored when full (full judged before any same-cycle pop); pop ignored when empty.
module pagerank_update_fifo
    import pagerank_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            i_push,
    input  logic            i_pop,
    input  scatter_update_t i_dat,
    output scatter_update_t o_dat,
    output logic            o_full,
    output logic            o_empty
);
    localparam int AW = $clog2(DEPTH);

    scatter_update_t r_mem [DEPTH];
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_dat   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push && !o_full)  r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (i_pop  && !o_empty) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (i_push && !o_full) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
    end

endmodule

// File: rtl/pagerank_scatter_arbiter.sv
// Iteration controller + round-robin merge of per-engine update FIFOs onto one gather port.
// Update reaches gather_* one edge after its push at the earliest; gather_* holds while stalled.
module pagerank_scatter_arbiter
    import pagerank_pkg::*;
#(
    parameter int NUM_SCATTER = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         iter_start,
    output logic                         scatter_start,
    output logic                         all_done,
    output logic [15:0]                  iter_count,
    pagerank_scatter_arbiter_if.slave    bus
);
    localparam int SRC_W = (NUM_SCATTER > 1) ? $clog2(NUM_SCATTER) : 1;

    ctrl_state_t            r_state;
    ctrl_state_t            w_state_nxt;
    logic [NUM_SCATTER-1:0] r_done_flags;
    logic [15:0]            r_iter_count;
    logic                   w_start;

    logic [NUM_SCATTER-1:0] w_full;
    logic [NUM_SCATTER-1:0] w_empty;
    logic [NUM_SCATTER-1:0] w_sc_ready;
    logic [NUM_SCATTER-1:0] w_push;
    logic [NUM_SCATTER-1:0] w_pop;
    scatter_update_t        w_fifo_dat [NUM_SCATTER];

    logic [SRC_W-1:0]       r_rr_ptr;
    logic [SRC_W-1:0]       w_grant;
    logic [SRC_W-1:0]       w_idx;
    logic                   w_found;
    logic                   w_any;
    logic                   w_load;

    logic                   r_gvld;
    scatter_update_t        r_gdat;
    logic [SRC_W-1:0]       r_gsrc;

    assign w_start = iter_start && ((r_state == IDLE) || (r_state == DONE));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (iter_start)            w_state_nxt = RUN;
            RUN:     if (&r_done_flags)         w_state_nxt = DRAIN;
            DRAIN:   if (!w_any && !r_gvld)     w_state_nxt = DONE;
            DONE:    if (iter_start)            w_state_nxt = RUN;
            default:                            w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        scatter_start = w_start;
        all_done      = (r_state == DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_done_flags <= '0;
            r_iter_count <= '0;
        end else begin
            if (w_start)              r_done_flags <= '0;
            else if (r_state == RUN)  r_done_flags <= r_done_flags | bus.sc_done;
            if ((r_state == DRAIN) && (w_state_nxt == DONE))
                r_iter_count <= r_iter_count + 16'd1;
        end
    end

    for (genvar k = 0; k < NUM_SCATTER; k++) begin : g_fifo
        scatter_update_t w_in;
        assign w_in          = {bus.sc_node_id[k], bus.sc_value[k]};
        assign w_sc_ready[k] = (r_state == RUN) && !w_full[k];
        assign w_push[k]     = bus.sc_valid[k] && w_sc_ready[k];
        assign w_pop[k]      = w_load && (w_grant == SRC_W'(k));

        pagerank_update_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clock   (clock),
            .reset_n (reset_n),
            .i_push  (w_push[k]),
            .i_pop   (w_pop[k]),
            .i_dat   (w_in),
            .o_dat   (w_fifo_dat[k]),
            .o_full  (w_full[k]),
            .o_empty (w_empty[k])
        );
    end

    assign w_any  = |(~w_empty);
    assign w_load = (!r_gvld || bus.gather_ready) && w_any;

    // First non-empty FIFO at or after the pointer, searching circularly.
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_SCATTER; i++) begin
            w_idx = SRC_W'((int'(r_rr_ptr) + i) % NUM_SCATTER);
            if (!w_found && !w_empty[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_gvld   <= 1'b0;
            r_gdat   <= '0;
            r_gsrc   <= '0;
            r_rr_ptr <= '0;
        end else if (w_load) begin
            r_gvld   <= 1'b1;
            r_gdat   <= w_fifo_dat[w_grant];
            r_gsrc   <= w_grant;
            r_rr_ptr <= (w_grant == SRC_W'(NUM_SCATTER - 1)) ? '0 : w_grant + SRC_W'(1);
        end else if (bus.gather_ready) begin
            r_gvld   <= 1'b0;
        end
    end

    assign bus.sc_ready       = w_sc_ready;
    assign bus.gather_valid   = r_gvld;
    assign bus.gather_node_id = r_gdat.node_id;
    assign bus.gather_value   = r_gdat.value;
    assign bus.gather_src     = r_gsrc;
    assign iter_count         = r_iter_count;

endmodule
